// File: rtl/occupancy_sequencer.sv
// Turns entry/exit sensor edges into add/remove command sequences for a downstream BCD occupancy counter.
// Build option: define OCCUPANCY_CAPACITY_LIMIT_EN to cap occupancy at MAX_OCCUPANCY instead of 99.
module occupancy_sequencer #(
    parameter int MAX_OCCUPANCY = 50
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       EnterReq,
    input  logic       ExitReq,
    output logic [7:0] Selector,
    output logic       Increment,
    output logic [6:0] Count,
    output logic       Full,
    output logic       Empty,
    output logic       Rejected,
    output logic       Overrun,
    output logic       Busy
);

`ifdef OCCUPANCY_CAPACITY_LIMIT_EN
    localparam logic [6:0] LIMIT = 7'(MAX_OCCUPANCY);
`else
    localparam logic [6:0] LIMIT = 7'd99;

    // MAX_OCCUPANCY stays on the interface so both builds share one port/parameter list
    logic w_unusedMaxOccupancy;
    assign w_unusedMaxOccupancy = ^MAX_OCCUPANCY;
`endif

    localparam logic [7:0] SEL_IDLE   = 8'd0;
    localparam logic [7:0] SEL_ADD    = 8'd4;
    localparam logic [7:0] SEL_REMOVE = 8'd20;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;

    logic       r_enterSample;
    logic       r_exitSample;
    logic [2:0] r_enterPend;
    logic [2:0] r_exitPend;
    logic       r_prioExit;
    logic       r_chanExit;
    logic [6:0] r_count;
    logic [7:0] r_selector;
    logic       r_increment;
    logic       r_rejected;
    logic       r_overrun;

    logic       w_enterEdge;
    logic       w_exitEdge;
    logic       w_enterWant;
    logic       w_exitWant;
    logic       w_pickExit;
    logic       w_serveEnter;
    logic       w_serveExit;
    logic       w_reject;
    logic       w_start;
    logic       w_countStep;
    logic [7:0] w_nextSelector;
    logic       w_nextIncrement;
    logic [3:0] w_enterStep;
    logic [3:0] w_exitStep;

    // Returns {overrun, nextPending}; an edge and a service in the same cycle cancel out
    function automatic logic [3:0] pendStep(input logic [2:0] pend,
                                            input logic       edgeIn,
                                            input logic       serve);
        logic [3:0] result;
        result = {1'b0, pend};
        if (edgeIn && !serve) begin
            if (pend == 3'd7) begin
                result = {1'b1, pend};
            end else begin
                result = {1'b0, pend + 3'd1};
            end
        end else if (!edgeIn && serve) begin
            result = {1'b0, pend - 3'd1};
        end
        return result;
    endfunction

    assign w_enterEdge = EnterReq & ~r_enterSample;
    assign w_exitEdge  = ExitReq & ~r_exitSample;
    assign w_enterWant = (r_enterPend != 3'd0);
    assign w_exitWant  = (r_exitPend != 3'd0);
    assign w_pickExit  = w_exitWant & (~w_enterWant | r_prioExit);

    always_comb begin
        w_nextState     = r_state;
        w_nextSelector  = SEL_IDLE;
        w_nextIncrement = 1'b0;
        w_serveEnter    = 1'b0;
        w_serveExit     = 1'b0;
        w_reject        = 1'b0;
        w_start         = 1'b0;
        w_countStep     = 1'b0;
        case (r_state)
            IDLE: begin
                // Saturated requests are retired here without ever touching the counter
                if (w_enterWant || w_exitWant) begin
                    if (w_pickExit) begin
                        w_serveExit = 1'b1;
                        w_reject    = (r_count == 7'd0);
                    end else begin
                        w_serveEnter = 1'b1;
                        w_reject     = (r_count == LIMIT);
                    end
                    w_start = ~w_reject;
                    if (w_start) begin
                        w_nextState    = SETUP;
                        w_nextSelector = w_pickExit ? SEL_REMOVE : SEL_ADD;
                    end
                end
            end
            SETUP: begin
                w_nextState     = STROBE;
                w_nextSelector  = r_chanExit ? SEL_REMOVE : SEL_ADD;
                w_nextIncrement = 1'b1;
                w_countStep     = 1'b1;
            end
            STROBE: begin
                w_nextState    = RELEASE;
                w_nextSelector = r_chanExit ? SEL_REMOVE : SEL_ADD;
            end
            RELEASE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_enterStep = pendStep(r_enterPend, w_enterEdge, w_serveEnter);
    assign w_exitStep  = pendStep(r_exitPend, w_exitEdge, w_serveExit);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_enterSample <= 1'b0;
            r_exitSample  <= 1'b0;
            r_enterPend   <= 3'd0;
            r_exitPend    <= 3'd0;
            r_prioExit    <= 1'b0;
            r_chanExit    <= 1'b0;
            r_count       <= 7'd0;
            r_selector    <= SEL_IDLE;
            r_increment   <= 1'b0;
            r_rejected    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_enterSample <= EnterReq;
            r_exitSample  <= ExitReq;
            r_enterPend   <= w_enterStep[2:0];
            r_exitPend    <= w_exitStep[2:0];
            r_selector    <= w_nextSelector;
            r_increment   <= w_nextIncrement;
            r_rejected    <= w_reject;
            r_overrun     <= w_enterStep[3] | w_exitStep[3];
            if (w_serveEnter || w_serveExit) begin
                r_prioExit <= ~r_prioExit;
            end
            if (w_start) begin
                r_chanExit <= w_pickExit;
            end
            // Shadow count moves on the same edge that raises Increment
            if (w_countStep) begin
                r_count <= r_chanExit ? (r_count - 7'd1) : (r_count + 7'd1);
            end
        end
    end

    assign Selector  = r_selector;
    assign Increment = r_increment;
    assign Count     = r_count;
    assign Full      = (r_count == LIMIT);
    assign Empty     = (r_count == 7'd0);
    assign Rejected  = r_rejected;
    assign Overrun   = r_overrun;
    assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_occupancy_sequencer.sv
// Bench for occupancy_sequencer: directed scenarios plus random sensor traffic, every cycle
// compared against a transaction-timeline model of occupancy, pending requests and priority.
module tb_occupancy_sequencer;

    localparam int MAX_OCC = 20;
`ifdef OCCUPANCY_CAPACITY_LIMIT_EN
    localparam int MODEL_LIMIT = MAX_OCC;
`else
    localparam int MODEL_LIMIT = 99;
`endif

    logic       Clock;
    logic       Reset;
    logic       EnterReq;
    logic       ExitReq;
    logic [7:0] Selector;
    logic       Increment;
    logic [6:0] Count;
    logic       Full;
    logic       Empty;
    logic       Rejected;
    logic       Overrun;
    logic       Busy;

    occupancy_sequencer #(
        .MAX_OCCUPANCY(MAX_OCC)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .EnterReq (EnterReq),
        .ExitReq  (ExitReq),
        .Selector (Selector),
        .Increment(Increment),
        .Count    (Count),
        .Full     (Full),
        .Empty    (Empty),
        .Rejected (Rejected),
        .Overrun  (Overrun),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int testsRun  = 0;
    int failCount = 0;

    // Model: pending request counts, occupancy, and position within the 4-cycle command timeline
    int mPendE = 0;
    int mPendX = 0;
    int mOcc   = 0;
    int mPhase = 0;
    bit mDirX  = 0;
    bit mPrioX = 0;
    bit mPrevE = 0;
    bit mPrevX = 0;
    bit mRej   = 0;
    bit mOvr   = 0;

    int incPulses = 0;
    int rejPulses = 0;
    int ovrPulses = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic e, input logic x, input logic r);
        int  netE;
        int  netX;
        bit  pickX;
        bit  decE;
        bit  decX;
        if (r) begin
            mPendE = 0; mPendX = 0; mOcc = 0; mPhase = 0; mDirX = 0;
            mPrioX = 0; mPrevE = 0; mPrevX = 0; mRej = 0; mOvr = 0;
        end else begin
            decE = 0;
            decX = 0;
            mRej = 0;
            mOvr = 0;
            if (mPhase == 0) begin
                if (mPendE > 0 || mPendX > 0) begin
                    pickX  = (mPendX > 0) && (mPendE == 0 || mPrioX);
                    mPrioX = !mPrioX;
                    if (pickX) begin
                        decX = 1;
                        if (mOcc == 0) mRej = 1;
                        else begin mPhase = 1; mDirX = 1; end
                    end else begin
                        decE = 1;
                        if (mOcc == MODEL_LIMIT) mRej = 1;
                        else begin mPhase = 1; mDirX = 0; end
                    end
                end
            end else if (mPhase == 1) begin
                mPhase = 2;
                mOcc   = mOcc + (mDirX ? -1 : 1);
            end else if (mPhase == 2) begin
                mPhase = 3;
            end else begin
                mPhase = 0;
            end
            netE = int'(e && !mPrevE) - int'(decE);
            netX = int'(x && !mPrevX) - int'(decX);
            if (netE > 0 && mPendE == 7) mOvr = 1;
            else mPendE = mPendE + netE;
            if (netX > 0 && mPendX == 7) mOvr = 1;
            else mPendX = mPendX + netX;
            mPrevE = e;
            mPrevX = x;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic x, input logic r);
        EnterReq = e;
        ExitReq  = x;
        Reset    = r;
        @(posedge Clock);
        modelStep(e, x, r);
        #1;
        checkOutput("selector",  Selector,  (mPhase != 0) ? (mDirX ? 20 : 4) : 0);
        checkOutput("increment", Increment, (mPhase == 2) ? 1 : 0);
        checkOutput("count",     Count,     mOcc);
        checkOutput("full",      Full,      (mOcc == MODEL_LIMIT) ? 1 : 0);
        checkOutput("empty",     Empty,     (mOcc == 0) ? 1 : 0);
        checkOutput("rejected",  Rejected,  mRej);
        checkOutput("overrun",   Overrun,   mOvr);
        checkOutput("busy",      Busy,      (mPhase != 0) ? 1 : 0);
        incPulses += int'(Increment === 1'b1);
        rejPulses += int'(Rejected === 1'b1);
        ovrPulses += int'(Overrun === 1'b1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearPulses();
        incPulses = 0;
        rejPulses = 0;
        ovrPulses = 0;
    endtask

    task automatic entryPulse();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(5);
    endtask

    task automatic exitPulse();
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(5);
    endtask

    initial begin
        logic e;
        logic x;
        EnterReq = 1'b0;
        ExitReq  = 1'b0;
        Reset    = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_count",    Count,     0);
        checkOutput("reset_empty",    Empty,     1);
        checkOutput("reset_selector", Selector,  0);
        checkOutput("reset_busy",     Busy,      0);
        idleCycles(3);

        // Exit at empty room is rejected without a strobe
        clearPulses();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("empty_exit_rejected", Rejected, 1);
        idleCycles(4);
        checkOutput("empty_exit_no_strobe", incPulses, 0);
        checkOutput("empty_exit_count",     Count,     0);

        // Single entry: command timeline relative to the detecting edge
        clearPulses();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("entry_k_busy", Busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("entry_k1_sel", Selector,  4);
        checkOutput("entry_k1_inc", Increment, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("entry_k2_inc",   Increment, 1);
        checkOutput("entry_k2_count", Count,     1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("entry_k3_inc", Increment, 0);
        checkOutput("entry_k3_sel", Selector,  4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("entry_k4_sel",  Selector, 0);
        checkOutput("entry_k4_busy", Busy,     0);
        checkOutput("entry_pulses",  incPulses, 1);

        // Raise occupancy to 5; six retired events leave priority on the entry side
        for (int i = 0; i < 4; i++) entryPulse();
        checkOutput("count_five", Count, 5);

        // Simultaneous entry and exit: entry served first
        clearPulses();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both_first_sel", Selector, 4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both_first_count", Count, 6);
        idleCycles(3);
        checkOutput("both_second_sel", Selector, 20);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both_second_count", Count, 5);
        idleCycles(3);
        checkOutput("both_pulses", incPulses, 2);

        // Reset during the strobe cycle aborts the command
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("abort_strobe_inc", Increment, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_inc",   Increment, 0);
        checkOutput("abort_sel",   Selector,  0);
        checkOutput("abort_count", Count,     0);
        clearPulses();
        idleCycles(6);
        checkOutput("abort_no_pulse", incPulses, 0);

        // Fill to the capacity limit and one beyond, then drain and one beyond
        clearPulses();
        for (int i = 0; i < MODEL_LIMIT + 1; i++) entryPulse();
        checkOutput("fill_count",    Count,     MODEL_LIMIT);
        checkOutput("fill_full",     Full,      1);
        checkOutput("fill_rejected", rejPulses, 1);
        checkOutput("fill_pulses",   incPulses, MODEL_LIMIT);
        clearPulses();
        for (int i = 0; i < MODEL_LIMIT + 1; i++) exitPulse();
        checkOutput("drain_count",    Count,     0);
        checkOutput("drain_empty",    Empty,     1);
        checkOutput("drain_rejected", rejPulses, 1);
        checkOutput("drain_pulses",   incPulses, MODEL_LIMIT);

        // Entry edges every 2 cycles outpace service: pending saturates and two edges are lost
        idleCycles(2);
        clearPulses();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        idleCycles(40);
        checkOutput("burst_overruns", ovrPulses, 2);
        checkOutput("burst_pulses",   incPulses, 16);
        checkOutput("burst_count",    Count,     16);

        // Random sensor traffic with occasional resets
        applyStimulus(1'b0, 1'b0, 1'b1);
        e = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) e = ~e;
            if ($urandom_range(0, 4) == 0) x = ~x;
            applyStimulus(e, x, ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
